// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_IALU = 3'd2,
        CL_LW   = 3'd3,
        CL_SW   = 3'd4,
        CL_BEQ  = 3'd5,
        CL_BNE  = 3'd6,
        CL_J    = 3'd7
    } class_t;

    localparam logic [OPC_W-1:0] OP_R     = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    // Result of decoding one instruction word.
    typedef struct packed {
        class_t              cls;
        logic [ALU_OP_W-1:0] alu_code;
        logic                is_signed;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational opcode/funct classifier: instruction class, ALU op, extend mode, illegal flag.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output dec_t               dec
);

    always_comb begin
        dec.cls       = CL_NONE;
        dec.alu_code  = ALU_ADD;
        dec.is_signed = 1'b0;
        dec.illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                dec.cls = CL_R;
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_code = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_code = ALU_SUB;
                    FN_AND:          dec.alu_code = ALU_AND;
                    FN_OR:           dec.alu_code = ALU_OR;
                    FN_NOR:          dec.alu_code = ALU_NOR;
                    FN_SLT:          dec.alu_code = ALU_SLT;
                    default: begin
                        dec.cls     = CL_NONE;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW:    begin dec.cls = CL_LW;   dec.is_signed = 1'b1; end
            OP_SW:    begin dec.cls = CL_SW;   dec.is_signed = 1'b1; end
            OP_BEQ:   begin dec.cls = CL_BEQ;  dec.is_signed = 1'b1; dec.alu_code = ALU_SUB; end
            OP_BNE:   begin dec.cls = CL_BNE;  dec.is_signed = 1'b1; dec.alu_code = ALU_SUB; end
            OP_J:           dec.cls = CL_J;
            OP_ADDI, OP_ADDIU: begin dec.cls = CL_IALU; dec.is_signed = 1'b1; end
            OP_SLTI:  begin dec.cls = CL_IALU; dec.is_signed = 1'b1; dec.alu_code = ALU_SLT; end
            OP_ANDI:  begin dec.cls = CL_IALU; dec.alu_code = ALU_AND; end
            OP_ORI:   begin dec.cls = CL_IALU; dec.alu_code = ALU_OR; end
            default:        dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, wait timeout and trap state.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CODE_W    = 4,
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned MEM_TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPC_W-1:0]      opcode,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  is_signed,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  jump,
    output logic                  branch,
    output logic [1:0]            alu_sel,
    output logic [ALU_CODE_W-1:0] ALU_Code,
    output logic                  instr_done,
    output logic                  fault,
    output logic [STATE_W-1:0]    state_o
);

    localparam int unsigned       CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    class_t              cls_q;
    logic [ALU_OP_W-1:0] alu_q;
    logic                sgn_q;
    logic [ALU_OP_W-1:0] alu_code;
    dec_t                dec;
    logic                done;
    logic                waiting;
    logic                timeout;

    mips_main_decoder u_dec (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    assign done    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !done;
    // The wait that would take the count to MEM_TIMEOUT traps instead.
    assign timeout = waiting && (cnt_q == CNT_LAST);
    assign cnt_d   = (state_d != state_q) ? '0 :
                     (waiting ? cnt_q + CNT_W'(1) : cnt_q);

    assign ALU_Code = ALU_CODE_W'(alu_code);
    assign state_o  = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            cls_q   <= CL_NONE;
            alu_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec.cls;
                alu_q <= dec.alu_code;
                sgn_q <= dec.is_signed;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        is_signed  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_sel    = 2'b00;
        alu_code   = '0;
        instr_done = 1'b0;
        fault      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                alu_sel  = 2'b10;
                alu_code = ALU_ADD;
                ir_write = done;
                pc_write = done;
                if (done)         state_d = ST_DECODE;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    state_d = ST_TRAP;
                end else if (dec.cls == CL_J) begin
                    jump       = 1'b1;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                is_signed = sgn_q;
                alu_code  = alu_q;
                case (cls_q)
                    CL_R:    state_d = ST_WB;
                    CL_IALU: begin alu_sel = 2'b01; state_d = ST_WB; end
                    CL_LW, CL_SW: begin alu_sel = 2'b01; state_d = ST_MEM; end
                    CL_BEQ, CL_BNE: begin
                        branch     = 1'b1;
                        instr_done = 1'b1;
                        pc_write   = (cls_q == CL_BEQ) ? zero : !zero;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                is_signed = sgn_q;
                alu_code  = alu_q;
                case (cls_q)
                    CL_LW: begin
                        mem_read = 1'b1;
                        if (done)         state_d = ST_WB;
                        else if (timeout) state_d = ST_TRAP;
                    end
                    CL_SW: begin
                        mem_write = 1'b1;
                        if (done) begin
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end else if (timeout) begin
                            state_d = ST_TRAP;
                        end
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_WB: begin
                is_signed  = sgn_q;
                alu_code   = alu_q;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = (cls_q == CL_R);
                mem_to_reg = (cls_q == CL_LW);
                state_d    = ST_FETCH;
            end
            ST_TRAP: fault = 1'b1;
            default: state_d = ST_TRAP;
        endcase
    end

endmodule
